spi_flash_writer: RTL and testbench

SPI Mode 3 master that services 6809 write cycles into the flash window. A write runs three steps: a Write Enable command (0x06), then a Page Program (0x02) with a 24-bit address and one data byte, then Read Status Register (0x05) polls until the Write-In-Progress bit clears. It sits beside the flash read controller on the same SPI pins; the top-level mux selects this block's pins while o_Busy is high. It stalls the CPU through o_MemoryReady.

---
 rtl/spi_flash_writer.sv | 202 ++++++++++++++++++++
 tb/tb_spi_flash_writer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_writer.sv
// SPI mode-3 flash write sequencer: WREN, page-program of one byte, then RDSR
// polling until WIP clears. Stalls the CPU and owns the SPI pins while busy.
module spi_flash_writer #(
  parameter logic [7:0]  CMD_WREN   = 8'h06,
  parameter logic [7:0]  CMD_PP     = 8'h02,
  parameter logic [7:0]  CMD_RDSR   = 8'h05,
  parameter int unsigned CS_GAP     = 4,
  parameter logic [15:0] POLL_LIMIT = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_we,
  input  logic [15:0] i_ADDRESS_BUS,
  input  logic [7:0]  i_DATA,
  input  logic        i_RW,
  input  logic        i_SPI_MISO,
  output logic        o_SPI_CLK,
  output logic        o_SPI_MOSI,
  output logic        o_SPI_CS,
  output logic        o_MemoryReady,
  output logic        o_Busy,
  output logic        o_Error
);

  localparam int unsigned     GAP_W     = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
  localparam int unsigned     SR_W      = 40;
  localparam logic [5:0]      LAST_WREN = 6'd7;
  localparam logic [5:0]      LAST_PROG = 6'd39;
  localparam logic [5:0]      LAST_POLL = 6'd15;

  typedef enum logic [2:0] {
    S_IDLE, S_WREN, S_GAP1, S_PROG, S_GAP2, S_POLL, S_PGAP, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             cs_q, cs_d, sck_q, sck_d, mosi_q, mosi_d;
  logic             rdy_q, rdy_d, busy_q, busy_d, err_q, err_d;
  logic [5:0]       bit_q, bit_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [15:0]      poll_q, poll_d;
  logic [23:0]      addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic [SR_W-1:0]  tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic             shifting, shift_end, gap_done;
  logic [5:0]       last_bit;

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    cs_d      = cs_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    rdy_d     = rdy_q;
    busy_d    = busy_q;
    err_d     = err_q;
    bit_d     = bit_q;
    gap_d     = gap_q;
    poll_d    = poll_q;
    addr_d    = addr_q;
    data_d    = data_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    shift_end = 1'b0;
    gap_done  = (gap_q == GAP_LAST);

    case (state_q)
      S_PROG:  last_bit = LAST_PROG;
      S_POLL:  last_bit = LAST_POLL;
      default: last_bit = LAST_WREN;
    endcase
    shifting = (state_q == S_WREN) || (state_q == S_PROG) || (state_q == S_POLL);

    // Two clk per bit: fall and present MOSI, then rise and sample MISO
    if (shifting) begin
      if (sck_q) begin
        sck_d  = 1'b0;
        mosi_d = tx_q[SR_W-1];
        tx_d   = {tx_q[SR_W-2:0], 1'b1};
      end else begin
        sck_d = 1'b1;
        rx_d  = {rx_q[6:0], i_SPI_MISO};
        if (bit_q == last_bit) begin
          shift_end = 1'b1;
          bit_d     = '0;
          cs_d      = 1'b1;
        end else begin
          bit_d = bit_q + 6'd1;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (spi_we && !i_RW) begin
          addr_d  = {8'h00, i_ADDRESS_BUS};
          data_d  = i_DATA;
          err_d   = 1'b0;
          poll_d  = '0;
          busy_d  = 1'b1;
          rdy_d   = 1'b0;
          cs_d    = 1'b0;
          tx_d    = {CMD_WREN, 32'hFFFF_FFFF};
          state_d = S_WREN;
        end
      end
      S_WREN: if (shift_end) state_d = S_GAP1;
      S_GAP1: begin
        mosi_d = 1'b1;
        gap_d  = gap_done ? '0 : gap_q + GAP_W'(1);
        if (gap_done) begin
          cs_d    = 1'b0;
          tx_d    = {CMD_PP, addr_q, data_q};
          state_d = S_PROG;
        end
      end
      S_PROG: if (shift_end) state_d = S_GAP2;
      S_GAP2: begin
        mosi_d = 1'b1;
        gap_d  = gap_done ? '0 : gap_q + GAP_W'(1);
        if (gap_done) begin
          cs_d    = 1'b0;
          tx_d    = {CMD_RDSR, 32'hFFFF_FFFF};
          state_d = S_POLL;
        end
      end
      S_POLL: begin
        if (shift_end) begin
          if (i_SPI_MISO && (poll_q != 16'hFFFF)) poll_d = poll_q + 16'd1;
          state_d = S_PGAP;
        end
      end
      // First gap cycle resolves the status byte captured at the end of POLL
      S_PGAP: begin
        mosi_d = 1'b1;
        if ((gap_q == '0) && !rx_q[0]) begin
          state_d = S_DONE;
        end else if ((gap_q == '0) && (poll_q >= POLL_LIMIT)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          gap_d = gap_done ? '0 : gap_q + GAP_W'(1);
          if (gap_done) begin
            cs_d    = 1'b0;
            tx_d    = {CMD_RDSR, 32'hFFFF_FFFF};
            state_d = S_POLL;
          end
        end
      end
      S_DONE: begin
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cs_q    <= 1'b1;
      sck_q   <= 1'b1;
      mosi_q  <= 1'b1;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      bit_q   <= '0;
      gap_q   <= '0;
      poll_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      poll_q  <= poll_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
    end
  end

  assign o_SPI_CLK     = sck_q;
  assign o_SPI_MOSI    = mosi_q;
  assign o_SPI_CS      = cs_q;
  assign o_MemoryReady = rdy_q;
  assign o_Busy        = busy_q;
  assign o_Error       = err_q;

endmodule

// File: tb/tb_spi_flash_writer.sv
// Directed bench for spi_flash_writer with a behavioural SPI flash that
// records every CS-framed transaction and answers RDSR polls.
module tb_spi_flash_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_we;
  logic [15:0] addr_bus;
  logic [7:0]  data_bus;
  logic        rw;
  logic        miso = 1'b0;
  logic        sck, mosi, cs, mem_rdy, busy, err;

  always #5 clk = ~clk;

  spi_flash_writer #(.POLL_LIMIT(16'd4)) dut (
    .clk           (clk),
    .rst           (rst),
    .spi_we        (spi_we),
    .i_ADDRESS_BUS (addr_bus),
    .i_DATA        (data_bus),
    .i_RW          (rw),
    .i_SPI_MISO    (miso),
    .o_SPI_CLK     (sck),
    .o_SPI_MOSI    (mosi),
    .o_SPI_CS      (cs),
    .o_MemoryReady (mem_rdy),
    .o_Busy        (busy),
    .o_Error       (err)
  );

  int chk_cnt  = 0;
  int fail_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flash model state (written only by the monitor)
  logic        sck_p = 1'b1, cs_p = 1'b1, mosi_p = 1'b1, busy_p = 1'b0;
  logic [39:0] bits = '0;
  int          nbits = 0;
  logic [39:0] trans_val [256];
  int          trans_len [256];
  int          trans_n = 0;
  int          gap_val [256];
  int          gap_n = 0;
  int          gap_run = 0;
  int          rdsr_n = 0;
  int          mr_low = 0;
  int          cs_low = 0;
  int          viol = 0;

  // Flash behaviour (written only by stimulus)
  int          wip_cfg = 0;
  bit          stuck_cfg = 1'b0;
  int          rdsr_base = 0;

  always @(negedge clk) begin
    if (!sck_p && sck) begin
      if (mosi !== mosi_p || cs_p) viol++;
      bits = {bits[38:0], mosi};
      nbits++;
    end
    if (sck_p && !sck) begin
      if (nbits == 15 && bits[14:7] == 8'h05)
        miso = stuck_cfg || ((rdsr_n - rdsr_base) < wip_cfg);
      else
        miso = 1'b0;
    end
    if (cs && !sck) viol++;
    if (!cs_p && cs) begin
      if (!sck) viol++;
      if (trans_n < 256) begin
        trans_val[trans_n] = bits;
        trans_len[trans_n] = nbits;
      end
      trans_n++;
      if (nbits == 16 && bits[15:8] == 8'h05) rdsr_n++;
      gap_run = 1;
    end else if (cs) begin
      gap_run++;
    end
    if (cs_p && !cs) begin
      if (!sck) viol++;
      if (busy_p && gap_n < 256) begin
        gap_val[gap_n] = gap_run;
        gap_n++;
      end
      nbits = 0;
      bits  = '0;
    end
    if (!mem_rdy) mr_low++;
    if (!cs) cs_low++;
    sck_p  = sck;
    cs_p   = cs;
    mosi_p = mosi;
    busy_p = busy;
  end

  // Issue one CPU write from a negedge and check the resulting SPI traffic
  task automatic write_and_check(input string name, input logic [15:0] a, input logic [7:0] d,
                                 input int wip, input bit stuck, input bit disturb,
                                 input int exp_polls, input logic exp_err);
    int t0, g0, m0, bad;
    bit done;
    t0 = trans_n; g0 = gap_n; m0 = mr_low;
    wip_cfg = wip; stuck_cfg = stuck; rdsr_base = rdsr_n;
    spi_we = 1'b1; rw = 1'b0; addr_bus = a; data_bus = d;
    @(negedge clk);
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (disturb && i < 60) begin
        spi_we   = i[0];
        data_bus = ~d;
        addr_bus = ~a;
      end else begin
        spi_we = 1'b0;
      end
      if (mem_rdy) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_latency"}, 64'(mr_low - m0), 64'(138 + (exp_polls - 1) * 36));
    check({name, "_ntrans"}, 64'(trans_n - t0), 64'(2 + exp_polls));
    check({name, "_wren"}, {24'd0, trans_val[t0]}, 64'h06);
    check({name, "_wren_len"}, 64'(trans_len[t0]), 64'd8);
    check({name, "_pp"}, {24'd0, trans_val[t0+1]}, {24'd0, 8'h02, 8'h00, a, d});
    check({name, "_pp_len"}, 64'(trans_len[t0+1]), 64'd40);
    bad = 0;
    for (int k = 0; k < exp_polls; k++)
      if (trans_len[t0+2+k] != 16 || trans_val[t0+2+k] !== 40'h05FF) bad++;
    check({name, "_rdsr_bad"}, 64'(bad), 64'd0);
    check({name, "_ngaps"}, 64'(gap_n - g0), 64'(1 + exp_polls));
    bad = 0;
    for (int k = g0; k < gap_n; k++)
      if (gap_val[k] != 4) bad++;
    check({name, "_gap_bad"}, 64'(bad), 64'd0);
    check({name, "_error"}, 64'(err), 64'(exp_err));
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_cs"}, 64'(cs), 64'd1);
  endtask

  initial begin
    int c0;
    rst = 1'b1; spi_we = 1'b0; rw = 1'b1; addr_bus = '0; data_bus = '0;
    repeat (3) @(negedge clk);
    check("rst_cs", 64'(cs), 64'd1);
    check("rst_sck", 64'(sck), 64'd1);
    check("rst_mosi", 64'(mosi), 64'd1);
    check("rst_ready", 64'(mem_rdy), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_error", 64'(err), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    write_and_check("t1", 16'h1234, 8'hA5, 0, 1'b0, 1'b0, 1, 1'b0);
    repeat (3) @(negedge clk);
    write_and_check("t2", 16'h4000, 8'h5A, 3, 1'b0, 1'b0, 4, 1'b0);
    repeat (3) @(negedge clk);
    write_and_check("t3", 16'h0BEE, 8'h11, 0, 1'b1, 1'b0, 4, 1'b1);
    check("t3_ready", 64'(mem_rdy), 64'd1);
    // Immediately after DONE: back-to-back accept, clears the sticky error
    write_and_check("t4", 16'h0001, 8'h22, 0, 1'b0, 1'b0, 1, 1'b0);

    // Reset in the middle of the PROG address bytes
    spi_we = 1'b1; rw = 1'b0; addr_bus = 16'h1234; data_bus = 8'h77;
    @(negedge clk);
    spi_we = 1'b0;
    repeat (50) @(negedge clk);
    for (int i = 0; i < 2 && !sck; i++) @(negedge clk);
    check("t5_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_cs", 64'(cs), 64'd1);
    check("t5_sck", 64'(sck), 64'd1);
    check("t5_mosi", 64'(mosi), 64'd1);
    check("t5_ready", 64'(mem_rdy), 64'd1);
    check("t5_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    write_and_check("t5_after", 16'hFFFF, 8'h3C, 0, 1'b0, 1'b0, 1, 1'b0);

    // Read cycle must not start a transaction
    repeat (2) @(negedge clk);
    c0 = cs_low;
    spi_we = 1'b1; rw = 1'b1; addr_bus = 16'h2222; data_bus = 8'h99;
    repeat (5) @(negedge clk);
    spi_we = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_cs_low", 64'(cs_low - c0), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_ready", 64'(mem_rdy), 64'd1);

    // Bus activity while busy must not disturb the latched write
    write_and_check("t7", 16'h0055, 8'hC3, 1, 1'b0, 1'b1, 2, 1'b0);
    repeat (10) @(negedge clk);
    check("t7_idle_after", 64'(busy), 64'd0);

    check("mode3_viol", 64'(viol), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
